// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared types and constants for the register-file writeback arbiter.
package rf_wb_pkg;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSU = 1'b1;
  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: synchronous FIFO of writeback requests with per-entry address taps for hazard lookup.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push,
  input  logic                 pop,
  input  wb_req_t              din,
  output logic                 full,
  output logic                 empty,
  output wb_req_t              head,
  output logic [DEPTH-1:0]     ent_valid,
  output logic [RF_ADDR_W-1:0] ent_addr [DEPTH]
);
  localparam int PW = $clog2(DEPTH);
  wb_req_t mem [DEPTH];
  logic [PW:0] wr_ptr, rd_ptr, cnt;
  assign cnt = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head = mem[rd_ptr[PW-1:0]];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PW-1:0]] <= din;
  end
  // An entry is live when its distance from the read pointer is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_valid[i] = {1'b0, PW'(i) - rd_ptr[PW-1:0]} < cnt;
    assign ent_addr[i] = mem[i].addr;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin merge of ALU/LSU writebacks onto the register file write port.
// Define RF_WB_PERF_EN to add the saturating conflict_cnt output.
module regfile_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_data,
  input  logic [ADDR_W-1:0] q_addr,
  output logic              q_pending,
`ifdef RF_WB_PERF_EN
  output logic [31:0]       conflict_cnt,
`endif
  output logic              w_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data
);
  logic full0, full1, empty0, empty1, push0, push1, pop0, pop1;
  logic rr_ptr, gnt, any, both;
  wb_req_t head0, head1, head;
  logic [DEPTH-1:0] v0, v1;
  logic [RF_ADDR_W-1:0] a0 [DEPTH];
  logic [RF_ADDR_W-1:0] a1 [DEPTH];
  assign s0_ready = !full0 && !rst && !flush;
  assign s1_ready = !full1 && !rst && !flush;
  assign push0 = s0_valid && s0_ready;
  assign push1 = s1_valid && s1_ready;
  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .rst(rst), .flush(flush), .push(push0), .pop(pop0),
    .din({s0_addr, s0_data}), .full(full0), .empty(empty0), .head(head0),
    .ent_valid(v0), .ent_addr(a0)
  );
  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst(rst), .flush(flush), .push(push1), .pop(pop1),
    .din({s1_addr, s1_data}), .full(full1), .empty(empty1), .head(head1),
    .ent_valid(v1), .ent_addr(a1)
  );
  // With a single candidate, empty0 alone selects it: 1 means only LSU holds data.
  always_comb begin
    both = !empty0 && !empty1;
    any = !empty0 || !empty1;
    gnt = both ? rr_ptr : empty0;
    pop0 = any && gnt == SRC_ALU;
    pop1 = any && gnt == SRC_LSU;
    head = gnt ? head1 : head0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      w_en <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
      rr_ptr <= 1'b0;
    end else if (flush) begin
      w_en <= 1'b0;
    end else begin
      w_en <= any && head.addr != '0;
      if (any) begin
        w_addr <= head.addr;
        w_data <= head.data;
      end
      if (both) rr_ptr <= !rr_ptr;
    end
  end
  always_comb begin
    q_pending = w_en && w_addr == q_addr;
    for (int i = 0; i < DEPTH; i++)
      q_pending = q_pending || (v0[i] && a0[i] == q_addr) || (v1[i] && a1[i] == q_addr);
    q_pending = q_pending && q_addr != '0;
  end
`ifdef RF_WB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) conflict_cnt <= '0;
    else if (both && !flush && conflict_cnt != 32'hFFFF_FFFF) conflict_cnt <= conflict_cnt + 1'b1;
  end
`endif
endmodule
